// File: rtl/miner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : miner_pkg
// Description : Shared types for the miner result path: nonce width and the
//               {golden, nonce} queue entry.
// Revision    : 1.0 - initial release
// ============================================================================
package miner_pkg;

  localparam int NONCE_W = 32;

  // One captured result: the golden nonce and the nonce counter snapshot.
  typedef struct packed {
    logic [NONCE_W-1:0] golden;
    logic [NONCE_W-1:0] nonce;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage : miner_pkg
`default_nettype wire

// File: rtl/nonce_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nonce_fifo
// Description : Generic synchronous FIFO, 2^DEPTH_LOG2 entries, head data read
//               combinationally. Pointers carry one extra wrap bit so full and
//               empty are distinguishable; storage itself is never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [WIDTH-1:0]      o_head
);

  localparam int                c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_PTR_ONE = 1;

  logic [WIDTH-1:0]    r_mem [0:c_DEPTH-1];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_pop_ok;
  logic                w_push_ok;

  // Full when the wrap bits differ but the index bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  // A pop frees the slot the same cycle, so a push into a full FIFO is fine then.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Storage write; contents are left unreset on purpose.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_push_data;
  end

endmodule : nonce_fifo
`default_nettype wire

// File: rtl/golden_nonce_queue.sv
`default_nettype none
// ============================================================================
// Module      : golden_nonce_queue
// Description : Detects new golden nonces from the miner, queues them with a
//               nonce snapshot, and presents them over a valid/ready stream.
//               Keeps wrapping found and saturating drop counters so a stalled
//               consumer never stalls hashing.
// Revision    : 1.0 - initial release
// ============================================================================
module golden_nonce_queue
  import miner_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int FOUND_W    = 16,
  parameter int DROP_W     = 8
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  input  logic [NONCE_W-1:0]   golden_nonce,
  input  logic [NONCE_W-1:0]   nonce,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NONCE_W-1:0]   out_golden,
  output logic [NONCE_W-1:0]   out_nonce,
  output logic [DEPTH_LOG2:0]  level,
  output logic [FOUND_W-1:0]   found_count,
  output logic [DROP_W-1:0]    drop_count
);

  localparam logic [FOUND_W-1:0] c_FOUND_ONE = 1;
  localparam logic [DROP_W-1:0]  c_DROP_ONE  = 1;

  logic [NONCE_W-1:0] r_prev_golden;
  logic [FOUND_W-1:0] r_found_count;
  logic [DROP_W-1:0]  r_drop_count;
  logic               w_event;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  entry_t             w_new_entry;
  entry_t             w_head;

  // A nonzero value that differs from last cycle is one event; a return to
  // zero re-arms detection of the same value.
  assign w_event     = (golden_nonce != '0) && (golden_nonce != r_prev_golden);
  assign w_pop       = out_valid && out_ready;
  assign w_push      = w_event && (!w_full || w_pop);
  assign w_new_entry = '{golden: golden_nonce, nonce: nonce};

  assign out_valid   = !w_empty;
  assign out_golden  = w_head.golden;
  assign out_nonce   = w_head.nonce;
  assign found_count = r_found_count;
  assign drop_count  = r_drop_count;

  // Edge-detector history plus found/drop statistics.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      r_prev_golden <= '0;
      r_found_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_prev_golden <= golden_nonce;
      if (w_event) r_found_count <= r_found_count + c_FOUND_ONE;
      if (w_event && !w_push && (r_drop_count != '1))
        r_drop_count <= r_drop_count + c_DROP_ONE;
    end
  end

  nonce_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk         (hash_clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (w_new_entry),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (level),
    .o_head      (w_head)
  );

endmodule : golden_nonce_queue
`default_nettype wire

// File: tb/tb_golden_nonce_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_golden_nonce_queue
// Description : Self-checking scoreboard bench for golden_nonce_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_golden_nonce_queue;
  import miner_pkg::*;

  localparam int DEPTH = 8;

  logic        hash_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [31:0] golden_nonce = '0;
  logic [31:0] nonce = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_golden;
  logic [31:0] out_nonce;
  logic [3:0]  level;
  logic [15:0] found_count;
  logic [7:0]  drop_count;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  entry_t      m_q[$];
  logic [31:0] m_prev = '0;
  int          m_found = 0;
  int          m_drop = 0;
  logic [31:0] nonce_ctr = 32'h40;

  golden_nonce_queue #(.DEPTH_LOG2(3), .FOUND_W(16), .DROP_W(8)) dut (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .golden_nonce(golden_nonce),
    .nonce       (nonce),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_golden  (out_golden),
    .out_nonce   (out_nonce),
    .level       (level),
    .found_count (found_count),
    .drop_count  (drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 64'(out_valid),   64'(m_q.size() != 0));
    check({tag, "_level"}, 64'(level),       64'(m_q.size()));
    check({tag, "_found"}, 64'(found_count), 64'(m_found[15:0]));
    check({tag, "_drop"},  64'(drop_count),  64'(m_drop));
  endtask

  task automatic model_clear();
    m_q.delete();
    m_prev  = '0;
    m_found = 0;
    m_drop  = 0;
  endtask

  // Drive one cycle of inputs, check any head being popped, then advance.
  task automatic step(input logic [31:0] g, input logic ready);
    int     lvl;
    logic   pop;
    logic   evt;
    entry_t e;
    golden_nonce = g;
    nonce        = nonce_ctr;
    out_ready    = ready;
    lvl = m_q.size();
    pop = (lvl != 0) && ready;
    evt = (g != 0) && (g != m_prev);
    if (pop) begin
      check("head_golden", 64'(out_golden), 64'(m_q[0].golden));
      check("head_nonce",  64'(out_nonce),  64'(m_q[0].nonce));
    end
    @(posedge hash_clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (evt) begin
      m_found++;
      if (lvl < DEPTH || pop) begin
        e.golden = g;
        e.nonce  = nonce_ctr;
        m_q.push_back(e);
      end else if (m_drop != 255) begin
        m_drop++;
      end
    end
    m_prev    = g;
    nonce_ctr = nonce_ctr + 32'd1;
    check_state("step");
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    golden_nonce = '0;
    out_ready    = 1'b0;
    #1;
    model_clear();
    check_state("rst");
    @(posedge hash_clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    // Idle after reset
    do_reset();
    for (int i = 0; i < 20; i++) step(32'h0, 1'b0);
    check("idle_found", 64'(found_count), 64'd0);

    // Single held value yields one entry
    do_reset();
    nonce_ctr = 32'h40;
    for (int i = 0; i < 10; i++) step(32'h1234_ABCD, 1'b0);
    check("hold_found", 64'(found_count), 64'd1);
    check("hold_level", 64'(level), 64'd1);
    check("hold_head",  64'(out_golden), 64'h1234_ABCD);
    check("hold_nonce", 64'(out_nonce), 64'h40);
    step(32'h0, 1'b1);

    // Overflow: nine events into eight slots
    do_reset();
    for (int i = 0; i < 9; i++) step(32'h1000_0001 + 32'(i), 1'b0);
    check("ovf_level", 64'(level), 64'd8);
    check("ovf_found", 64'(found_count), 64'd9);
    check("ovf_drop",  64'(drop_count), 64'd1);
    // Full with coincident pop and event: no drop, new entry goes last
    step(32'hCAFE_0009, 1'b1);
    check("fullpop_level", 64'(level), 64'd8);
    check("fullpop_drop",  64'(drop_count), 64'd1);
    for (int i = 0; i < 9; i++) step(32'h0, 1'b1);
    check("drain_empty", 64'(out_valid), 64'd0);

    // A, 0, A gives two events
    do_reset();
    step(32'h5555_AAAA, 1'b0);
    step(32'h0, 1'b0);
    step(32'h5555_AAAA, 1'b0);
    check("rearm_found", 64'(found_count), 64'd2);
    check("rearm_level", 64'(level), 64'd2);
    for (int i = 0; i < 3; i++) step(32'h0, 1'b1);

    // Asynchronous reset with five entries queued
    do_reset();
    step(32'h11, 1'b0);
    step(32'h22, 1'b0);
    step(32'h33, 1'b0);
    step(32'h44, 1'b0);
    step(32'hDEAD_BEEF, 1'b0);
    check("pre_rst_level", 64'(level), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_level", 64'(level), 64'd0);
    check("async_found", 64'(found_count), 64'd0);
    check("async_drop",  64'(drop_count), 64'd0);
    #3;
    reset = 1'b0;
    step(32'hDEAD_BEEF, 1'b0);
    check("post_rst_found", 64'(found_count), 64'd1);
    check("post_rst_level", 64'(level), 64'd1);
    step(32'hDEAD_BEEF, 1'b1);
    step(32'hDEAD_BEEF, 1'b1);
    check("post_rst_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_golden_nonce_queue
`default_nettype wire
